// File: rtl/mnist_pixel_window.sv
// -----------------------------------------------------------------------------
// mnist_pixel_window
//
// Input-side receiver of the MNIST CNN pixel stream. Takes a raster-order
// pixel stream (one pixel per accepted cycle, IMG_W x IMG_H per frame),
// buffers K-1 previous rows and emits every fully populated KxK window
// ("valid" convolution, no padding) one cycle after its bottom-right pixel
// is accepted. A one-cycle frame_done pulse marks acceptance of the last
// pixel of a frame.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   frame_start  forces the raster position to (0,0) this cycle
//   pixel_valid  pixel_in is accepted this cycle
//   pixel_in     pixel value
//   win_out      KxK window, win_out[DATA_W*(r*K+c) +: DATA_W],
//                r=0 top (oldest) row, c=0 leftmost column
//   win_valid    one-cycle pulse: win_out/win_row/win_col hold a new window
//   win_row      window row  = bottom row - (K-1)
//   win_col      window col  = right col  - (K-1)
//   frame_done   one-cycle pulse, last pixel of the frame was accepted
// -----------------------------------------------------------------------------
module mnist_pixel_window #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int DATA_W = 8,
  localparam int COL_W = $clog2(IMG_W),
  localparam int ROW_W = $clog2(IMG_H)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  pixel_valid,
  input  logic [DATA_W-1:0]     pixel_in,
  output logic [K*K*DATA_W-1:0] win_out,
  output logic                  win_valid,
  output logic [ROW_W-1:0]      win_row,
  output logic [COL_W-1:0]      win_col,
  output logic                  frame_done
);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_WIN0  = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] ROW_WIN0  = ROW_W'(K - 1);
  // Last row that is still only filling the line buffers.
  localparam logic [ROW_W-1:0] ROW_FILLZ = ROW_W'(K - 2);

  typedef enum logic {
    FILL   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t            state_p0;
  state_t            state_eff;
  state_t            state_nxt;
  logic [COL_W-1:0]  col_p0;
  logic [COL_W-1:0]  col_eff;
  logic [COL_W-1:0]  col_nxt;
  logic [ROW_W-1:0]  row_p0;
  logic [ROW_W-1:0]  row_eff;
  logic [ROW_W-1:0]  row_nxt;
  logic              accept;
  logic              last_pix;
  logic              emit;

  // Line buffers are addressed by column: lb_p0[0][c] is the pixel one row
  // above the current position at column c, lb_p0[j][c] is j+1 rows above.
  logic [DATA_W-1:0]     lb_p0   [K-1][IMG_W];
  logic [DATA_W-1:0]     win_sr  [K][K];
  logic [DATA_W-1:0]     win_nxt [K][K];
  logic [DATA_W-1:0]     new_col [K];
  logic [K*K*DATA_W-1:0] win_flat;

  // frame_start overrides the stored position and state in the same cycle,
  // so a pixel presented alongside it is taken as (0,0) of a fresh frame.
  always_comb begin
    col_eff   = frame_start ? '0 : col_p0;
    row_eff   = frame_start ? '0 : row_p0;
    state_eff = frame_start ? FILL : state_p0;
  end

  assign accept   = pixel_valid;
  assign last_pix = (row_eff == ROW_LAST) && (col_eff == COL_LAST);
  // A window is complete only once K columns of the current row are in, so
  // windows never straddle a row boundary or mix rows of two frames.
  assign emit     = accept && (state_eff == ACTIVE) && (col_eff >= COL_WIN0);

  always_comb begin
    state_nxt = state_eff;
    col_nxt   = col_eff;
    row_nxt   = row_eff;
    if (accept) begin
      if (col_eff == COL_LAST) begin
        col_nxt = '0;
        if (last_pix) begin
          row_nxt   = '0;
          state_nxt = FILL;
        end else begin
          row_nxt = row_eff + 1'b1;
          if (row_eff == ROW_FILLZ) begin
            state_nxt = ACTIVE;
          end
        end
      end else begin
        col_nxt = col_eff + 1'b1;
      end
    end
  end

  // New right-hand column: buffered rows on top, incoming pixel at the bottom.
  always_comb begin
    for (int r = 0; r < K - 1; r++) begin
      new_col[r] = lb_p0[K-2-r][col_eff];
    end
    new_col[K-1] = pixel_in;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_nxt[r][c] = win_sr[r][c+1];
      end
      win_nxt[r][K-1] = new_col[r];
    end
    win_flat = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_flat[DATA_W*(r*K+c) +: DATA_W] = win_nxt[r][c];
      end
    end
  end

  // ---- stage p0: raster position, FSM state, line buffers, window shift ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p0 <= FILL;
      col_p0   <= '0;
      row_p0   <= '0;
    end else begin
      state_p0 <= state_nxt;
      col_p0   <= col_nxt;
      row_p0   <= row_nxt;
    end
  end

  // Buffer contents are never emitted before being rewritten in the current
  // frame, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_p0[0][col_eff] <= pixel_in;
      for (int j = 1; j < K - 1; j++) begin
        lb_p0[j][col_eff] <= lb_p0[j-1][col_eff];
      end
      win_sr <= win_nxt;
    end
  end

  // ---- stage p1: registered window outputs, held until the next window ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_out    <= '0;
      win_row    <= '0;
      win_col    <= '0;
    end else begin
      win_valid  <= emit;
      frame_done <= accept && last_pix;
      if (emit) begin
        win_out <= win_flat;
        win_row <= row_eff - ROW_WIN0;
        win_col <= col_eff - COL_WIN0;
      end
    end
  end

endmodule

// File: tb/tb_mnist_pixel_window.sv
// -----------------------------------------------------------------------------
// Testbench for mnist_pixel_window: ramp / inverted-ramp / random frames with
// and without idle gaps, back-to-back frames, frame_start abort and mid-frame
// reset. Every cycle the outputs are compared with a frame-array reference
// model; a table of hand-computed windows pins down specific positions.
// -----------------------------------------------------------------------------
module tb_mnist_pixel_window;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int K     = 3;
  localparam int DW    = 8;
  localparam int WIN_W = K * K * DW;
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NWIN  = (IMG_W - K + 1) * (IMG_H - K + 1);
  localparam int CTR   = (K / 2) * K + (K / 2);

  logic             clk = 1'b0;
  logic             rst;
  logic             frame_start;
  logic             pixel_valid;
  logic [DW-1:0]    pixel_in;
  logic [WIN_W-1:0] win_out;
  logic             win_valid;
  logic [ROW_W-1:0] win_row;
  logic [COL_W-1:0] win_col;
  logic             frame_done;

  mnist_pixel_window #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .K     (K),
    .DATA_W(DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .pixel_valid(pixel_valid),
    .pixel_in   (pixel_in),
    .win_out    (win_out),
    .win_valid  (win_valid),
    .win_row    (win_row),
    .win_col    (win_col),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int win_cnt;
  int done_cnt;

  // Reference model: the current frame as a 2-D image plus expected outputs.
  logic [DW-1:0]    img [IMG_H][IMG_W];
  int               mr, mc;
  logic             e_vld, e_done;
  logic [WIN_W-1:0] e_win;
  int               e_row, e_col;

  typedef struct {
    int          idx;
    bit          vld;
    logic [7:0]  tl;
    logic [7:0]  ctr;
    logic [7:0]  br;
    int          wrow;
    int          wcol;
    bit          done;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [WIN_W-1:0] act,
                     input logic [WIN_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mr = 0; mc = 0;
    e_vld = 1'b0; e_done = 1'b0; e_win = '0; e_row = 0; e_col = 0;
  endtask

  task automatic model_step(input bit fs, input bit pv, input logic [DW-1:0] px);
    if (fs) begin
      mr = 0; mc = 0;
    end
    e_vld  = 1'b0;
    e_done = 1'b0;
    if (pv) begin
      img[mr][mc] = px;
      if (mr >= K - 1 && mc >= K - 1) begin
        e_vld = 1'b1;
        e_row = mr - (K - 1);
        e_col = mc - (K - 1);
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            e_win[DW*(i*K+j) +: DW] = img[mr-(K-1)+i][mc-(K-1)+j];
      end
      if (mr == IMG_H - 1 && mc == IMG_W - 1) e_done = 1'b1;
      mc++;
      if (mc == IMG_W) begin
        mc = 0;
        mr++;
        if (mr == IMG_H) mr = 0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("win_valid",  WIN_W'(win_valid),  WIN_W'(e_vld));
    chk("frame_done", WIN_W'(frame_done), WIN_W'(e_done));
    chk("win_out",    win_out,            e_win);
    chk("win_row",    WIN_W'(win_row),    WIN_W'(e_row));
    chk("win_col",    WIN_W'(win_col),    WIN_W'(e_col));
    if (win_valid)  win_cnt++;
    if (frame_done) done_cnt++;
  endtask

  // Inputs are applied just after a rising edge; outputs checked 1 time unit
  // after the next rising edge.
  task automatic step(input bit fs, input bit pv, input logic [DW-1:0] px);
    frame_start = fs;
    pixel_valid = pv;
    pixel_in    = px;
    model_step(fs, pv, px);
    @(posedge clk);
    #1;
    check_outputs();
    frame_start = 1'b0;
    pixel_valid = 1'b0;
  endtask

  function automatic logic [DW-1:0] pix(input int kind, input int idx);
    logic [DW-1:0] v;
    v = DW'(idx);
    if (kind == 1) v = ~v;
    else if (kind == 2) v = DW'($urandom);
    return v;
  endfunction

  task automatic run_frame(input int kind, input bit gaps, input bit first_fs,
                           input bit table_on, input int n);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, '0);
      step(first_fs && (i == 0), 1'b1, pix(kind, i));
      if (table_on) begin
        for (int t = 0; t < 6; t++) begin
          if (tbl[t].idx == i) begin
            chk("tbl_vld", WIN_W'(win_valid), WIN_W'(tbl[t].vld));
            chk("tbl_done", WIN_W'(frame_done), WIN_W'(tbl[t].done));
            if (tbl[t].vld) begin
              chk("tbl_tl",  WIN_W'(win_out[0 +: DW]),        WIN_W'(tbl[t].tl));
              chk("tbl_ctr", WIN_W'(win_out[DW*CTR +: DW]),   WIN_W'(tbl[t].ctr));
              chk("tbl_br",  WIN_W'(win_out[DW*(K*K-1) +: DW]), WIN_W'(tbl[t].br));
              chk("tbl_row", WIN_W'(win_row), WIN_W'(tbl[t].wrow));
              chk("tbl_col", WIN_W'(win_col), WIN_W'(tbl[t].wcol));
            end
          end
        end
      end
      if (kind == 1 && i == 58) begin
        chk("inv_first_vld", WIN_W'(win_valid), WIN_W'(1));
        chk("inv_first_tl",  WIN_W'(win_out[0 +: DW]), WIN_W'(8'hFF));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{58,  1'b1, 8'h00, 8'h1D, 8'h3A, 0,  0,  1'b0};
    tbl[1] = '{59,  1'b1, 8'h01, 8'h1E, 8'h3B, 0,  1,  1'b0};
    tbl[2] = '{84,  1'b0, 8'h00, 8'h00, 8'h00, 0,  0,  1'b0};
    tbl[3] = '{86,  1'b1, 8'h1C, 8'h39, 8'h56, 1,  0,  1'b0};
    tbl[4] = '{400, 1'b1, 8'h56, 8'h73, 8'h90, 12, 6,  1'b0};
    tbl[5] = '{783, 1'b1, 8'hD5, 8'hF2, 8'h0F, 25, 25, 1'b1};

    frame_start = 1'b0;
    pixel_valid = 1'b0;
    pixel_in    = '0;
    win_cnt     = 0;
    done_cnt    = 0;
    model_reset();

    // Reset state
    rst = 1'b1;
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b1;

    // Continuous ramp frame
    win_cnt = 0; done_cnt = 0;
    run_frame(0, 1'b0, 1'b0, 1'b1, NPIX);
    chk("ramp_windows", WIN_W'(win_cnt),  WIN_W'(NWIN));
    chk("ramp_done",    WIN_W'(done_cnt), WIN_W'(1));

    // Ramp frame with random idle gaps
    win_cnt = 0; done_cnt = 0;
    run_frame(0, 1'b1, 1'b0, 1'b1, NPIX);
    repeat (2) step(1'b0, 1'b0, '0);
    chk("gap_windows", WIN_W'(win_cnt),  WIN_W'(NWIN));
    chk("gap_done",    WIN_W'(done_cnt), WIN_W'(1));

    // Back-to-back ramp then inverted ramp
    run_frame(0, 1'b0, 1'b0, 1'b0, NPIX);
    win_cnt = 0; done_cnt = 0;
    run_frame(1, 1'b0, 1'b0, 1'b0, NPIX);
    chk("b2b_windows", WIN_W'(win_cnt),  WIN_W'(NWIN));
    chk("b2b_done",    WIN_W'(done_cnt), WIN_W'(1));

    // Random frame aborted at pixel 300 by frame_start with a pixel
    run_frame(2, 1'b0, 1'b0, 1'b0, 300);
    win_cnt = 0; done_cnt = 0;
    run_frame(2, 1'b0, 1'b1, 1'b0, NPIX);
    chk("abort_windows", WIN_W'(win_cnt),  WIN_W'(NWIN));
    chk("abort_done",    WIN_W'(done_cnt), WIN_W'(1));

    // One-cycle reset at pixel 400, then a full ramp frame
    run_frame(0, 1'b0, 1'b0, 1'b0, 400);
    rst = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b1;
    win_cnt = 0; done_cnt = 0;
    run_frame(0, 1'b0, 1'b0, 1'b1, NPIX);
    chk("rst_windows", WIN_W'(win_cnt),  WIN_W'(NWIN));
    chk("rst_done",    WIN_W'(done_cnt), WIN_W'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
